// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM state encoding for the uart_stream block.
// Optional parity support in the block is selected with the UART_PARITY_EN macro.
package uart_pkg;

  // Oversampling ticks per data bit and the tick index treated as mid-bit.
  localparam int OVERSAMPLE = 16;
  localparam int MID_BIT    = 7;

  localparam logic [7:0] TICK_LAST = 8'(OVERSAMPLE - 1);
  localparam logic [7:0] MID_LAST  = 8'(MID_BIT);

  // Common encoding for the TX and RX frame FSMs. ST_PARITY is only reached
  // in builds with parity enabled.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock first-word-fall-through FIFO. DEPTH must be a
// power of two so the pointers wrap naturally. Push when full and pop when
// empty are ignored.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DATA_SIZE-1:0]   wdata_i,
  output logic [DATA_SIZE-1:0]   rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  // Occupancy follows accepted pushes minus accepted pops.
  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level state; storage is not reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_stream.sv
// uart_stream: UART with runtime baud divisor, 16x oversampling and TX/RX
// FIFOs on valid/ready streams. Define UART_PARITY_EN to add a parity bit
// (parity_odd input, rx_parity_err output).
module uart_stream
  import uart_pkg::*;
#(
  parameter int DBITS      = 8,
  parameter int SB_TICK    = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_BITS   = 16
) (
  input  logic                        clk_100MHz,
  input  logic                        reset,
  input  logic [DIV_BITS-1:0]         divisor,
  input  logic                        rx,
  output logic                        tx,
  input  logic [DBITS-1:0]            tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [DBITS-1:0]            rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        tx_busy,
  output logic                        rx_frame_err,
  output logic                        rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic [$clog2(FIFO_DEPTH):0] rx_level
`ifdef UART_PARITY_EN
  ,
  input  logic                        parity_odd,
  output logic                        rx_parity_err
`endif
);

  localparam logic [7:0] SB_LAST = 8'(SB_TICK - 1);
  localparam logic [3:0] DB_LAST = 4'(DBITS - 1);

  // ---------------- baud tick ----------------
  logic [DIV_BITS-1:0] baud_cnt_q, baud_div_q;
  logic                tick;

  assign tick = (baud_cnt_q == baud_div_q);

  // Divisor is captured at each wrap so a change never truncates a period.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      baud_cnt_q <= '0;
      baud_div_q <= divisor;
    end else if (tick) begin
      baud_cnt_q <= '0;
      baud_div_q <= divisor;
    end else begin
      baud_cnt_q <= baud_cnt_q + DIV_BITS'(1);
    end
  end

  // ---------------- FIFOs ----------------
  logic             tx_full, tx_empty, tx_pop;
  logic [DBITS-1:0] tx_head;
  logic             rx_full, rx_empty, rx_push;
  logic [DBITS-1:0] rx_shreg_q, rx_shreg_d;

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;

  uart_sync_fifo #(.DATA_SIZE(DBITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk_100MHz), .reset(reset),
    .push_i(tx_valid && tx_ready), .pop_i(tx_pop), .wdata_i(tx_data),
    .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level)
  );

  uart_sync_fifo #(.DATA_SIZE(DBITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk_100MHz), .reset(reset),
    .push_i(rx_push), .pop_i(rx_ready && rx_valid), .wdata_i(rx_shreg_q),
    .rdata_o(rx_data), .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
  );

  // ---------------- transmitter ----------------
  uart_state_e      tx_state_q, tx_state_d;
  logic [7:0]       tx_tcnt_q, tx_tcnt_d;
  logic [3:0]       tx_bcnt_q, tx_bcnt_d;
  logic [DBITS-1:0] tx_shreg_q, tx_shreg_d;
  logic             tx_q, tx_d, tx_load;
`ifdef UART_PARITY_EN
  logic             tx_par_q, tx_par_d;
`endif

  // TX state and registered line driver.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      tx_shreg_q <= '0;
      tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_shreg_q <= tx_shreg_d;
      tx_q       <= tx_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // TX next state; a word is fetched on a tick from IDLE, or straight out of
  // STOP so consecutive frames have no idle gap.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_shreg_d = tx_shreg_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      ST_IDLE: if (tick && !tx_empty) begin
        tx_load    = 1'b1;
        tx_state_d = ST_START;
      end
      ST_START: if (tick) begin
        if (tx_tcnt_q == TICK_LAST) begin
          tx_state_d = ST_DATA;
          tx_tcnt_d  = '0;
          tx_bcnt_d  = '0;
        end else tx_tcnt_d = tx_tcnt_q + 8'd1;
      end
      ST_DATA: if (tick) begin
        if (tx_tcnt_q == TICK_LAST) begin
          tx_tcnt_d  = '0;
          tx_shreg_d = {1'b0, tx_shreg_q[DBITS-1:1]};
          if (tx_bcnt_q == DB_LAST) begin
`ifdef UART_PARITY_EN
            tx_state_d = ST_PARITY;
`else
            tx_state_d = ST_STOP;
`endif
          end else tx_bcnt_d = tx_bcnt_q + 4'd1;
        end else tx_tcnt_d = tx_tcnt_q + 8'd1;
      end
`ifdef UART_PARITY_EN
      ST_PARITY: if (tick) begin
        if (tx_tcnt_q == TICK_LAST) begin
          tx_state_d = ST_STOP;
          tx_tcnt_d  = '0;
        end else tx_tcnt_d = tx_tcnt_q + 8'd1;
      end
`endif
      ST_STOP: if (tick) begin
        if (tx_tcnt_q == SB_LAST) begin
          if (!tx_empty) begin
            tx_load    = 1'b1;
            tx_state_d = ST_START;
          end else tx_state_d = ST_IDLE;
        end else tx_tcnt_d = tx_tcnt_q + 8'd1;
      end
      default: tx_state_d = ST_IDLE;
    endcase
    if (tx_load) begin
      tx_shreg_d = tx_head;
      tx_tcnt_d  = '0;
    end
  end

  // TX outputs: line level derived from the upcoming state so tx is a flop.
  always_comb begin
    tx_pop = tx_load;
`ifdef UART_PARITY_EN
    tx_par_d = tx_load ? (^tx_head ^ parity_odd) : tx_par_q;
`endif
    case (tx_state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = tx_shreg_d[0];
`ifdef UART_PARITY_EN
      ST_PARITY: tx_d = tx_par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_state_q != ST_IDLE);

  // ---------------- receiver ----------------
  logic        rx_meta_q, rx_sync_q;
  uart_state_e rx_state_q, rx_state_d;
  logic [7:0]  rx_tcnt_q, rx_tcnt_d;
  logic [3:0]  rx_bcnt_q, rx_bcnt_d;
  logic        rx_done, rx_word_ok, frame_err_d, overrun_d;
  logic        rx_frame_err_q, rx_overrun_q;
`ifdef UART_PARITY_EN
  logic        rx_par_q, rx_par_d, rx_par_bad, parity_err_d, rx_parity_err_q;
`endif

  // Two-flop synchronizer on the asynchronous serial input; idles high.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX state and registered error pulses.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rx_state_q     <= ST_IDLE;
      rx_tcnt_q      <= '0;
      rx_bcnt_q      <= '0;
      rx_shreg_q     <= '0;
      rx_frame_err_q <= 1'b0;
      rx_overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q        <= 1'b0;
      rx_parity_err_q <= 1'b0;
`endif
    end else begin
      rx_state_q     <= rx_state_d;
      rx_tcnt_q      <= rx_tcnt_d;
      rx_bcnt_q      <= rx_bcnt_d;
      rx_shreg_q     <= rx_shreg_d;
      rx_frame_err_q <= frame_err_d;
      rx_overrun_q   <= overrun_d;
`ifdef UART_PARITY_EN
      rx_par_q        <= rx_par_d;
      rx_parity_err_q <= parity_err_d;
`endif
    end
  end

  // RX next state: confirm start at mid-bit, then sample every 16 ticks.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_shreg_d = rx_shreg_q;
    rx_done    = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_d   = rx_par_q;
`endif
    case (rx_state_q)
      ST_IDLE: if (!rx_sync_q) begin
        rx_state_d = ST_START;
        rx_tcnt_d  = '0;
      end
      ST_START: if (tick) begin
        if (rx_tcnt_q == MID_LAST) begin
          if (!rx_sync_q) begin
            rx_state_d = ST_DATA;
            rx_tcnt_d  = '0;
            rx_bcnt_d  = '0;
          end else rx_state_d = ST_IDLE;
        end else rx_tcnt_d = rx_tcnt_q + 8'd1;
      end
      ST_DATA: if (tick) begin
        if (rx_tcnt_q == TICK_LAST) begin
          rx_tcnt_d  = '0;
          rx_shreg_d = {rx_sync_q, rx_shreg_q[DBITS-1:1]};
          if (rx_bcnt_q == DB_LAST) begin
`ifdef UART_PARITY_EN
            rx_state_d = ST_PARITY;
`else
            rx_state_d = ST_STOP;
`endif
          end else rx_bcnt_d = rx_bcnt_q + 4'd1;
        end else rx_tcnt_d = rx_tcnt_q + 8'd1;
      end
`ifdef UART_PARITY_EN
      ST_PARITY: if (tick) begin
        if (rx_tcnt_q == TICK_LAST) begin
          rx_par_d   = rx_sync_q;
          rx_tcnt_d  = '0;
          rx_state_d = ST_STOP;
        end else rx_tcnt_d = rx_tcnt_q + 8'd1;
      end
`endif
      ST_STOP: if (tick) begin
        if (rx_tcnt_q == SB_LAST) begin
          rx_done    = 1'b1;
          rx_state_d = ST_IDLE;
        end else rx_tcnt_d = rx_tcnt_q + 8'd1;
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // RX outputs: accept the word on a good stop bit, else flag the error.
  always_comb begin
    rx_word_ok  = rx_done && rx_sync_q;
    frame_err_d = rx_done && !rx_sync_q;
`ifdef UART_PARITY_EN
    rx_par_bad   = ((^rx_shreg_q) ^ rx_par_q) != parity_odd;
    parity_err_d = rx_word_ok && rx_par_bad;
    rx_word_ok   = rx_word_ok && !rx_par_bad;
`endif
    rx_push   = rx_word_ok && !rx_full;
    overrun_d = rx_word_ok && rx_full;
  end

  assign rx_frame_err = rx_frame_err_q;
  assign rx_overrun   = rx_overrun_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = rx_parity_err_q;
`endif

endmodule

// File: tb/tb_uart_stream.sv
// tb_uart_stream: directed, table-driven bench for uart_stream at divisor=3
// (one bit = 64 clocks). Parity check runs only when UART_PARITY_EN is set.
module tb_uart_stream;

  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   divisor = 16'd3;
  logic          rx, rx_drv = 1'b1, loop = 1'b0;
  logic          tx, tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0;
  logic [7:0]    tx_data = '0, rx_data;
  logic          tx_busy, rx_frame_err, rx_overrun;
  logic [LW-1:0] tx_level, rx_level;
`ifdef UART_PARITY_EN
  logic          parity_odd = 1'b0;
  logic          rx_parity_err;
`endif

  always #5 clk = ~clk;
  assign rx = loop ? tx : rx_drv;

  uart_stream #(.DBITS(8), .SB_TICK(16), .FIFO_DEPTH(16), .DIV_BITS(16)) dut (
    .clk_100MHz(clk), .reset(reset), .divisor(divisor), .rx(rx), .tx(tx),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_busy(tx_busy), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
    .tx_level(tx_level), .rx_level(rx_level)
`ifdef UART_PARITY_EN
    , .parity_odd(parity_odd), .rx_parity_err(rx_parity_err)
`endif
  );

  int errors = 0, checks = 0;
  int fe_cnt = 0, ov_cnt = 0;

  // Count cycles on which each error pulse is high.
  always @(negedge clk) begin
    if (rx_frame_err) fe_cnt <= fe_cnt + 1;
    if (rx_overrun)   ov_cnt <= ov_cnt + 1;
  end

  typedef struct {
    int unsigned off;
    logic        exp_tx;
    logic        exp_busy;
  } tx_vec_t;

  tx_vec_t    txv[10];
  logic [7:0] lbw[3];
  logic [7:0] ovw[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one word on tx_valid until accepted; called at a negedge.
  task automatic push_word(input logic [7:0] w);
    int n = 0;
    tx_data  = w;
    tx_valid = 1'b1;
    while (!tx_ready && n < 20000) begin @(negedge clk); n++; end
    if (!tx_ready) chk("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, {31'd0, rx_valid}, 32'd1);
    chk(name, {24'd0, rx_data}, {24'd0, exp});
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // Wait for the start bit, then measure its length; returns at bit0 start.
  task automatic start_bit(output int len);
    int n = 0;
    while (tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    chk("start_seen", {31'd0, tx}, 32'd0);
    len = 0;
    while (tx === 1'b0 && len < 200) begin @(negedge clk); len++; end
  endtask

  // Drive a frame on rx; stop_low>0 holds the stop bit low for that many clocks.
  task automatic send_frame(input logic [7:0] d, input int stop_low);
    rx_drv = 1'b0;
    repeat (64) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx_drv = d[k];
      repeat (64) @(negedge clk);
    end
    if (stop_low > 0) begin
      rx_drv = 1'b0;
      repeat (stop_low) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (64) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, n, el, fe0, ov0;

    // 0xA5 LSB first: 1,0,1,0,0,1,0,1; stop at 512..575; idle afterwards.
    txv[0] = '{32,  1'b1, 1'b1};
    txv[1] = '{96,  1'b0, 1'b1};
    txv[2] = '{160, 1'b1, 1'b1};
    txv[3] = '{224, 1'b0, 1'b1};
    txv[4] = '{288, 1'b0, 1'b1};
    txv[5] = '{352, 1'b1, 1'b1};
    txv[6] = '{416, 1'b0, 1'b1};
    txv[7] = '{480, 1'b1, 1'b1};
    txv[8] = '{544, 1'b1, 1'b1};
    txv[9] = '{600, 1'b1, 1'b0};
    lbw = '{8'h00, 8'hFF, 8'h5A};
    ovw = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78, 8'h89,
            8'h9A, 8'hAB, 8'hBC, 8'hCD, 8'hDE, 8'hEF, 8'hF0, 8'h0F};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_errs", {30'd0, rx_frame_err, rx_overrun}, 32'd0);
    chk("rst_levels", {22'd0, tx_level, rx_level}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // TX waveform of 0xA5.
    push_word(8'hA5);
    start_bit(len);
    chk("start_len", len, 32'd64);
    chk("tx_level_after_pop", {27'd0, tx_level}, 32'd0);
    el = 0;
    for (int i = 0; i < 10; i++) begin
      while (el < int'(txv[i].off)) begin @(negedge clk); el++; end
      chk($sformatf("a5_tx[%0d]", i), {31'd0, tx}, {31'd0, txv[i].exp_tx});
      chk($sformatf("a5_busy[%0d]", i), {31'd0, tx_busy}, {31'd0, txv[i].exp_busy});
    end

    // 20-clock low glitch on rx is rejected silently.
    fe0 = fe_cnt;
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_level", {27'd0, rx_level}, 32'd0);
    chk("glitch_ferr", fe_cnt - fe0, 32'd0);

    // 0x3C with a low stop bit, released shortly after mid-stop.
    send_frame(8'h3C, 48);
    repeat (200) @(negedge clk);
    chk("ferr_pulses", fe_cnt - fe0, 32'd1);
    chk("ferr_level", {27'd0, rx_level}, 32'd0);
    send_frame(8'h3C, 0);
    repeat (100) @(negedge clk);
    chk("good_after_ferr_level", {27'd0, rx_level}, 32'd1);
    pop_chk("good_after_ferr", 8'h3C);

    // Loopback of three back-to-back words.
    fe0 = fe_cnt;
    loop = 1'b1;
    for (int i = 0; i < 3; i++) push_word(lbw[i]);
    n = 0;
    while (rx_level != 5'd3 && n < 4000) begin @(negedge clk); n++; end
    chk("loop_level", {27'd0, rx_level}, 32'd3);
    chk("loop_ferr", fe_cnt - fe0, 32'd0);
    for (int i = 0; i < 3; i++) pop_chk($sformatf("loop_word[%0d]", i), lbw[i]);
    n = 0;
    while (tx_busy && n < 1000) begin @(negedge clk); n++; end

    // Overrun: 17 words into a 16-deep RX FIFO that is never drained.
    ov0 = ov_cnt;
    for (int i = 0; i < 17; i++) push_word(ovw[i]);
    chk("tx_full_level", {27'd0, tx_level}, 32'd16);
    chk("tx_full_ready", {31'd0, tx_ready}, 32'd0);
    n = 0;
    while ((tx_busy || tx_level != 0) && n < 15000) begin @(negedge clk); n++; end
    repeat (100) @(negedge clk);
    chk("ovr_level", {27'd0, rx_level}, 32'd16);
    chk("ovr_pulses", ov_cnt - ov0, 32'd1);
    for (int i = 0; i < 16; i++) pop_chk($sformatf("ovr_word[%0d]", i), ovw[i]);
    chk("ovr_drained", {27'd0, rx_level}, 32'd0);
    loop = 1'b0;

    // Reset in the middle of a 0x00 data phase.
    push_word(8'h00);
    start_bit(len);
    repeat (96) @(negedge clk);
    chk("pre_rst_tx", {31'd0, tx}, 32'd0);
    push_word(8'h55);
    chk("pre_rst_level", {27'd0, tx_level}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_level", {27'd0, tx_level}, 32'd0);
    chk("mid_rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

`ifdef UART_PARITY_EN
    // Even parity of 0x07 is 1; parity bit spans 512..575 after bit0 start.
    parity_odd = 1'b0;
    push_word(8'h07);
    start_bit(len);
    repeat (544) @(negedge clk);
    chk("parity_bit", {31'd0, tx}, 32'd1);
    repeat (200) @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
